// File: rtl/alu_regfile_sequencer.sv
// Operand fetch / write-back sequencer around a combinational ALU.
// One command per three cycles: IDLE accept, EXEC capture, DONE pulse.
module alu_regfile_sequencer #(
  parameter int bit_depth = 8,
  parameter int reg_count = 4,
  localparam int AW = $clog2(reg_count)
) (
  input  logic                 IN_CLK,
  input  logic                 IN_RST_N,
  input  logic                 IN_CMD_VALID,
  output logic                 OUT_CMD_READY,
  input  logic [3:0]           IN_CMD_OP,
  input  logic [AW-1:0]        IN_CMD_DST,
  input  logic [AW-1:0]        IN_CMD_SRC_A,
  input  logic [AW-1:0]        IN_CMD_SRC_B,
  input  logic                 IN_CMD_IMM_EN,
  input  logic [bit_depth-1:0] IN_CMD_IMM,
  output logic [3:0]           OUT_ALU_OP,
  output logic [bit_depth-1:0] OUT_ALU_A,
  output logic [bit_depth-1:0] OUT_ALU_B,
  input  logic [bit_depth-1:0] IN_ALU_R,
  output logic                 OUT_RES_VALID,
  output logic [bit_depth-1:0] OUT_RES,
  output logic [AW-1:0]        OUT_RES_DST,
  output logic                 OUT_RES_ZERO,
  output logic                 OUT_RES_ERR,
  input  logic [AW-1:0]        IN_DBG_ADDR,
  output logic [bit_depth-1:0] OUT_DBG_DATA
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_MOV = 4'd10;

  logic [1:0]           state_q, state_d;
  logic [bit_depth-1:0] regs_q [reg_count];
  logic [bit_depth-1:0] regs_d [reg_count];
  logic [3:0]           op_q, op_d;
  logic [bit_depth-1:0] a_q, a_d;
  logic [bit_depth-1:0] b_q, b_d;
  logic [AW-1:0]        dst_q, dst_d;
  logic                 vld_q, vld_d;
  logic [bit_depth-1:0] res_q, res_d;
  logic [AW-1:0]        rdst_q, rdst_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  logic is_alu;
  logic is_mov;

  assign is_alu = (op_q <= 4'd9);
  assign is_mov = (op_q == OP_MOV);

  assign OUT_CMD_READY = (state_q == S_IDLE);
  assign OUT_ALU_OP    = op_q;
  assign OUT_ALU_A     = a_q;
  assign OUT_ALU_B     = b_q;
  assign OUT_RES_VALID = vld_q;
  assign OUT_RES       = res_q;
  assign OUT_RES_DST   = rdst_q;
  assign OUT_RES_ZERO  = zero_q;
  assign OUT_RES_ERR   = err_q;
  assign OUT_DBG_DATA  = regs_q[IN_DBG_ADDR];

  // Next-state: accept in IDLE, write back in EXEC, retire pulse in DONE.
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    vld_d   = vld_q;
    res_d   = res_q;
    rdst_d  = rdst_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (IN_CMD_VALID) begin
          op_d    = IN_CMD_OP;
          a_d     = regs_q[IN_CMD_SRC_A];
          b_d     = IN_CMD_IMM_EN ? IN_CMD_IMM
                                  : regs_q[IN_CMD_SRC_B];
          dst_d   = IN_CMD_DST;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu: begin
            res_d         = IN_ALU_R;
            regs_d[dst_q] = IN_ALU_R;
            err_d         = 1'b0;
          end
          is_mov: begin
            res_d         = b_q;
            regs_d[dst_q] = b_q;
            err_d         = 1'b0;
          end
          default: begin
            res_d = '0;
            err_d = 1'b1;
          end
        endcase
        vld_d   = 1'b1;
        rdst_d  = dst_q;
        zero_d  = (res_d == '0);
        state_d = S_DONE;
      end
      S_DONE: begin
        vld_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and register file; reset aborts any command in flight.
  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      state_q <= S_IDLE;
      for (int i = 0; i < reg_count; i++) begin
        regs_q[i] <= '0;
      end
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dst_q  <= '0;
      vld_q  <= 1'b0;
      res_q  <= '0;
      rdst_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      rdst_q  <= rdst_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// Bench for alu_regfile_sequencer: directed plan plus random commands.
// Checks against an array-based register file model and an ALU stub.
module tb_alu_regfile_sequencer;

  localparam int W  = 8;
  localparam int RC = 4;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_a;
  logic [AW-1:0] cmd_b;
  logic          cmd_imm_en;
  logic [W-1:0]  cmd_imm;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_r;
  logic          res_valid;
  logic [W-1:0]  res;
  logic [AW-1:0] res_dst;
  logic          res_zero;
  logic          res_err;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  int n_tests;
  int n_fail;

  logic [W-1:0] mregs [RC];

  alu_regfile_sequencer #(
    .bit_depth(W),
    .reg_count(RC)
  ) dut (
    .IN_CLK        (clk),
    .IN_RST_N      (rst_n),
    .IN_CMD_VALID  (cmd_valid),
    .OUT_CMD_READY (cmd_ready),
    .IN_CMD_OP     (cmd_op),
    .IN_CMD_DST    (cmd_dst),
    .IN_CMD_SRC_A  (cmd_a),
    .IN_CMD_SRC_B  (cmd_b),
    .IN_CMD_IMM_EN (cmd_imm_en),
    .IN_CMD_IMM    (cmd_imm),
    .OUT_ALU_OP    (alu_op),
    .OUT_ALU_A     (alu_a),
    .OUT_ALU_B     (alu_b),
    .IN_ALU_R      (alu_r),
    .OUT_RES_VALID (res_valid),
    .OUT_RES       (res),
    .OUT_RES_DST   (res_dst),
    .OUT_RES_ZERO  (res_zero),
    .OUT_RES_ERR   (res_err),
    .IN_DBG_ADDR   (dbg_addr),
    .OUT_DBG_DATA  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in; shifts/rotates use b[2:0], undefined ops give junk.
  function automatic logic [W-1:0] alu_fn(
    input logic [3:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [2*W-1:0] t;
    int s;
    s = int'(b[2:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << s;
      4'd3: return a >> s;
      4'd4: begin
        t = {a, a} << s;
        return t[2*W-1:W];
      end
      4'd5: begin
        t = {a, a} >> s;
        return t[W-1:0];
      end
      4'd6: return ~a;
      4'd7: return a & b;
      4'd8: return a | b;
      4'd9: return a ^ b;
      default: return ~b ^ 8'h5A;
    endcase
  endfunction

  always_comb alu_r = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < RC; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk(tag, 32'(dbg_data), 32'(mregs[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RC; i++) mregs[i] = '0;
  endtask

  // Full command: call at a negedge with the DUT in IDLE.
  task automatic run_cmd(
    input logic [3:0] op,
    input logic [AW-1:0] d,
    input logic [AW-1:0] sa,
    input logic [AW-1:0] sb,
    input logic ie,
    input logic [W-1:0] imm
  );
    logic [W-1:0] ea, eb, er;
    logic ill;
    ea  = mregs[sa];
    eb  = ie ? imm : mregs[sb];
    ill = (op > 4'd10);
    if (op == 4'd10) er = eb;
    else if (ill) er = '0;
    else er = alu_fn(op, ea, eb);
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_dst    = d;
    cmd_a      = sa;
    cmd_b      = sb;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_op     = 4'($urandom);
    cmd_imm    = W'($urandom);
    cmd_a      = AW'($urandom);
    cmd_b      = AW'($urandom);
    chk("ready_exec", 32'(cmd_ready), 32'd0);
    chk("vld_exec", 32'(res_valid), 32'd0);
    chk("alu_op", 32'(alu_op), 32'(op));
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    @(negedge clk);
    if (!ill) mregs[d] = er;
    chk("vld_done", 32'(res_valid), 32'd1);
    chk("res", 32'(res), 32'(er));
    chk("res_dst", 32'(res_dst), 32'(d));
    chk("res_zero", 32'(res_zero), 32'(er == '0));
    chk("res_err", 32'(res_err), 32'(ill));
    chk("ready_done", 32'(cmd_ready), 32'd0);
    dbg_addr = d;
    #1;
    chk("dbg_dst", 32'(dbg_data), 32'(mregs[d]));
    @(negedge clk);
    chk("vld_clr", 32'(res_valid), 32'd0);
    chk("err_clr", 32'(res_err), 32'd0);
    chk("res_hold", 32'(res), 32'(er));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("vld_rst", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("ready_rst", 32'(cmd_ready), 32'd1);
    chk("vld_rst2", 32'(res_valid), 32'd0);
    check_all_regs("dbg_rst");
  endtask

  initial begin
    int acc [$];
    n_tests    = 0;
    n_fail     = 0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_dst    = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_imm_en = 1'b0;
    cmd_imm    = '0;
    dbg_addr   = '0;
    rst_n      = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    run_cmd(4'd10, 2'd1, 2'd0, 2'd0, 1'b1, 8'h3C);
    run_cmd(4'd10, 2'd2, 2'd0, 2'd0, 1'b1, 8'hC4);
    run_cmd(4'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    chk("add_wrap", 32'(res), 32'h00);
    chk("add_zero", 32'(res_zero), 32'd1);
    run_cmd(4'd1, 2'd1, 2'd1, 2'd0, 1'b1, 8'h0C);
    chk("sub_self", 32'(mregs[1]), 32'h30);
    run_cmd(4'd13, 2'd2, 2'd1, 2'd1, 1'b0, 8'hFF);
    check_all_regs("dbg_ill");
    run_cmd(4'd9, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);

    cmd_op     = 4'd10;
    cmd_dst    = 2'd0;
    cmd_imm_en = 1'b1;
    cmd_imm    = 8'h77;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) acc.push_back(i);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    mregs[0] = 8'h77;
    chk("bp_count", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) begin
      chk("bp_gap", 32'(acc[1] - acc[0]), 32'd3);
    end
    check_all_regs("dbg_bp");

    run_cmd(4'd10, 2'd2, 2'd0, 2'd0, 1'b1, 8'h99);
    cmd_valid  = 1'b1;
    cmd_op     = 4'd10;
    cmd_dst    = 2'd3;
    cmd_imm    = 8'hAB;
    cmd_imm_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_exec", 32'(cmd_ready), 32'd0);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_nopulse", 32'(res_valid), 32'd0);
    end
    check_all_regs("dbg_rst3");

    for (int k = 0; k < 200; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                       : 4'($urandom_range(0, 10));
      run_cmd(op, AW'($urandom), AW'($urandom), AW'($urandom),
              1'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_all_regs("dbg_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
